// File: rtl/galetron_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : galetron_mem_pkg
// Purpose  : Shared loader FSM encoding and default memory geometry.
// Revision : 1.0 - initial release
// ============================================================================
package galetron_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage : galetron_mem_pkg
`default_nettype wire

// File: rtl/instruction_ram_core.sv
`default_nettype none
// ============================================================================
// Module   : instruction_ram_core
// Purpose  : Single-write, single-read instruction storage with a registered
//            read port and write-first bypass on same-address collisions.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
);

  // Depth widened by one bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  read_in_range;
  logic                  write_hit;

  assign read_in_range = ({1'b0, read_address} < DEPTH_EXT);
  assign write_hit     = write_enable && (write_address == read_address);

  // Storage write port; deliberately not reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  // Registered read port: out-of-range reads give zero, collisions give new data.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) begin
        if (!read_in_range) begin
          read_data <= '0;
        end else if (write_hit) begin
          read_data <= write_data;
        end else begin
          read_data <= mem[read_address];
        end
      end
    end
  end

endmodule : instruction_ram_core
`default_nettype wire

// File: rtl/instruction_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_ram_loader
// Purpose  : Burst loader that streams instruction words into an internal
//            RAM with a running XOR checksum, plus an independent fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_ram_loader
  import galetron_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base_address,
  input  logic [ADDR_WIDTH:0]   load_length,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [DATA_WIDTH-1:0] load_checksum,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_WORD  = (ADDR_WIDTH+1)'(1);

  loader_state_t         state;
  loader_state_t         next_state;
  logic [ADDR_WIDTH-1:0] address;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] address_next;
  logic                  transfer;

  assign transfer     = load_valid && (state == LOAD);
  assign address_next = (address == LAST_ADDR) ? '0 : address + 1'b1;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          next_state = (load_length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        if (transfer && (remaining == ONE_WORD)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Burst address, remaining count and checksum bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      address       <= '0;
      remaining     <= '0;
      load_checksum <= '0;
    end else begin
      if ((state == IDLE) && load_start) begin
        load_checksum <= '0;
        if (load_length != '0) begin
          address   <= load_base_address;
          remaining <= load_length;
        end
      end else if (transfer) begin
        address       <= address_next;
        remaining     <= remaining - ONE_WORD;
        load_checksum <= load_checksum ^ load_data;
      end
    end
  end

  instruction_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (transfer),
    .write_address (address),
    .write_data    (load_data),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_valid    (read_valid)
  );

endmodule : instruction_ram_loader
`default_nettype wire

// File: tb/tb_instruction_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_ram_loader
// Purpose  : Directed self-checking bench for instruction_ram_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_ram_loader;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 1024;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base_address;
  logic [ADDR_WIDTH:0]   load_length;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;
  logic [DATA_WIDTH-1:0] load_checksum;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  instruction_ram_loader #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .load_start        (load_start),
    .load_base_address (load_base_address),
    .load_length       (load_length),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_busy         (load_busy),
    .load_done         (load_done),
    .load_checksum     (load_checksum),
    .read_enable       (read_enable),
    .read_address      (read_address),
    .read_data         (read_data),
    .read_valid        (read_valid)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_burst(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] len);
    load_start        = 1'b1;
    load_base_address = base;
    load_length       = len;
    tick();
    load_start        = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic valid);
    load_data  = data;
    load_valid = valid;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] expected);
    read_enable  = 1'b1;
    read_address = addr;
    tick();
    read_enable  = 1'b0;
    check({tag, "_valid"}, {31'b0, read_valid}, 32'd1);
    check(tag, read_data, expected);
  endtask

  logic [31:0] words_a [4] = '{32'h11, 32'h22, 32'h44, 32'h88};
  logic [31:0] words_w [4] = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
  logic [ADDR_WIDTH-1:0] wrap_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};

  initial begin
    reset = 1'b1; load_start = 1'b0; load_base_address = '0; load_length = '0;
    load_data = '0; load_valid = 1'b0; read_enable = 1'b0; read_address = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_ready",    {31'b0, load_ready}, 32'd0);
    check("rst_busy",     {31'b0, load_busy},  32'd0);
    check("rst_done",     {31'b0, load_done},  32'd0);
    check("rst_rvalid",   {31'b0, read_valid}, 32'd0);
    check("rst_checksum", load_checksum,       32'd0);
    check("rst_rdata",    read_data,           32'd0);

    // Basic 4-word burst at 0x010
    start_burst(10'h010, 11'd4);
    for (int i = 0; i < 4; i++) begin
      check("b1_ready", {31'b0, load_ready}, 32'd1);
      check("b1_busy",  {31'b0, load_busy},  32'd1);
      check("b1_done_early", {31'b0, load_done}, 32'd0);
      push(words_a[i], 1'b1);
    end
    check("b1_done",     {31'b0, load_done},  32'd1);
    check("b1_ready_off", {31'b0, load_ready}, 32'd0);
    check("b1_checksum", load_checksum, 32'h0000_00FF);
    tick();
    check("b1_done_gone", {31'b0, load_done}, 32'd0);
    check("b1_idle_busy", {31'b0, load_busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_check("b1_read", 10'h010 + 10'(i), words_a[i]);
    end
    // read_data holds when no fetch is issued
    tick();
    check("hold_rvalid", {31'b0, read_valid}, 32'd0);
    check("hold_rdata",  read_data, words_a[3]);

    // Address wrap at DEPTH
    start_burst(10'd1022, 11'd4);
    for (int i = 0; i < 4; i++) push(words_w[i], 1'b1);
    check("wrap_done", {31'b0, load_done}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) read_check("wrap_read", wrap_addr[i], words_w[i]);

    // valid toggling 1,0,1,0,1 during a 3-word burst over 0x011..0x013
    start_burst(10'h011, 11'd3);
    check("tog_ready0", {31'b0, load_ready}, 32'd1); push(32'h0000_0B01, 1'b1);
    check("tog_ready1", {31'b0, load_ready}, 32'd1); push(32'h0BAD_0BAD, 1'b0);
    check("tog_ready2", {31'b0, load_ready}, 32'd1); push(32'h0000_0B02, 1'b1);
    check("tog_ready3", {31'b0, load_ready}, 32'd1); push(32'h0BAD_1BAD, 1'b0);
    check("tog_ready4", {31'b0, load_ready}, 32'd1);
    check("tog_done_early", {31'b0, load_done}, 32'd0);
    push(32'h0000_0B04, 1'b1);
    check("tog_done",     {31'b0, load_done}, 32'd1);
    check("tog_checksum", load_checksum, 32'h0000_0B07);
    tick();
    read_check("tog_read0", 10'h011, 32'h0000_0B01);
    read_check("tog_read1", 10'h012, 32'h0000_0B02);
    read_check("tog_read2", 10'h013, 32'h0000_0B04);
    read_check("tog_below", 10'h010, 32'h11);

    // Same-cycle read and write of address 5
    start_burst(10'd5, 11'd1);
    read_enable  = 1'b1;
    read_address = 10'd5;
    push(32'hDEAD_BEEF, 1'b1);
    read_enable  = 1'b0;
    check("wf_rvalid", {31'b0, read_valid}, 32'd1);
    check("wf_rdata",  read_data, 32'hDEAD_BEEF);
    tick();

    // Zero-length burst: immediate DONE, no write
    load_valid = 1'b1;
    load_data  = 32'h5A5A_5A5A;
    start_burst(10'h010, 11'd0);
    check("zl_done",     {31'b0, load_done}, 32'd1);
    check("zl_busy",     {31'b0, load_busy}, 32'd0);
    check("zl_checksum", load_checksum, 32'd0);
    tick();
    load_valid = 1'b0;
    check("zl_done_gone", {31'b0, load_done}, 32'd0);
    check("zl_busy_idle", {31'b0, load_busy}, 32'd0);
    read_check("zl_mem", 10'h010, 32'h11);

    // Reset after the 2nd word of a 5-word burst
    start_burst(10'h200, 11'd5);
    push(32'hC000_0000, 1'b1);
    push(32'hC000_0001, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab_busy",  {31'b0, load_busy},  32'd0);
    check("ab_ready", {31'b0, load_ready}, 32'd0);
    check("ab_done",  {31'b0, load_done},  32'd0);
    check("ab_checksum", load_checksum, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_no_done", {31'b0, load_done}, 32'd0);
    end
    read_check("ab_read0", 10'h200, 32'hC000_0000);
    read_check("ab_read1", 10'h201, 32'hC000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_instruction_ram_loader
`default_nettype wire

// File: doc/instruction_ram_loader.md
INSTRUCTION_RAM_LOADER -- requirements
Module: instruction_ram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, word address width in bits.
REQ-003 Parameter DEPTH, default 1024, number of words, SHALL be <= 2**ADDR_WIDTH.
REQ-004 clock  in  1  single clock; all state updates on posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load_start  in  1  one-cycle request to begin a load burst.
REQ-007 load_base_address  in  ADDR_WIDTH  first word address of the burst, sampled with load_start.
REQ-008 load_length  in  ADDR_WIDTH+1  number of words in the burst, sampled with load_start.
REQ-009 load_data  in  DATA_WIDTH  instruction word offered by the producer.
REQ-010 load_valid  in  1  load_data is valid.
REQ-011 load_ready  out  1  loader accepts load_data this cycle.
REQ-012 load_busy  out  1  burst in progress.
REQ-013 load_done  out  1  one-cycle pulse when the burst completes.
REQ-014 load_checksum  out  DATA_WIDTH  XOR of all words accepted in the current or last burst.
REQ-015 read_enable  in  1  fetch request.
REQ-016 read_address  in  ADDR_WIDTH  fetch word address.
REQ-017 read_data  out  DATA_WIDTH  registered fetch result.
REQ-018 read_valid  out  1  read_data holds a fetch result issued the previous cycle.

Function
REQ-019 FSM states: IDLE, LOAD, DONE; the reset state SHALL be IDLE.
REQ-020 IDLE with load_start=1 and load_length!=0: latch the base address and length, clear load_checksum, go to LOAD.
REQ-021 IDLE with load_start=1 and load_length=0: go directly to DONE with no memory write, and clear load_checksum.
REQ-022 load_start SHALL be ignored in LOAD and DONE.
REQ-023 load_ready SHALL be 1 only in LOAD; a word transfers on any cycle with load_valid and load_ready both 1.
REQ-024 Each transfer writes load_data to the current address, increments the address modulo DEPTH (DEPTH-1 wraps to 0), decrements the remaining count, and XORs load_data into load_checksum.
REQ-025 The transfer that brings the remaining count to 0 moves the FSM to DONE; load_ready SHALL be 0 in the following cycle.
REQ-026 DONE lasts exactly one cycle, asserts load_done, then returns to IDLE.
REQ-027 load_busy SHALL equal (state==LOAD).
REQ-028 A read with read_enable=1 SHALL present mem[read_address] on read_data one cycle later with read_valid=1; read_valid SHALL otherwise be 0 and read_data SHALL hold its last value.
REQ-029 Reads are permitted in every state.
REQ-030 A read and a write to the same address in the same cycle SHALL return the new (written) word (write-first).
REQ-031 A read_address >= DEPTH SHALL return all zeros; a write address >= DEPTH cannot occur because of the modulo wrap.
REQ-032 Burst latency SHALL be load_length transfer cycles plus 1 DONE cycle; throughput SHALL be one word per cycle.

Reset
REQ-033 On reset: state IDLE; load_ready, load_busy, load_done and read_valid 0; load_checksum 0; read_data 0; internal address and count 0.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset during LOAD SHALL abort the burst: words already written stay written, and no load_done pulse is produced.

Structure
REQ-036 The FSM state encoding and the default DATA_WIDTH and ADDR_WIDTH constants SHALL live in a shared package, galetron_mem_pkg.
REQ-037 The storage array SHALL be a sub-module, instruction_ram_core, with one synchronous write port, one registered read port and write-first bypass; the loader FSM is the parent.

Verification
REQ-038 Reset, then load_start with base=0x010, length=4 and words 0x11,0x22,0x44,0x88 on consecutive cycles -> load_done one cycle after the 4th transfer, load_checksum=0xFF; reads of addresses 0x010..0x013 return those four words.
REQ-039 Base=1022, length=4, DEPTH=1024 -> words land at 1022, 1023, 0, 1; readback confirms all four.
REQ-040 load_valid toggling 1,0,1,0 during a 3-word burst -> exactly 3 writes, with load_ready held 1 throughout LOAD.
REQ-041 Read of address 5 in the same cycle as a write of 0xDEADBEEF to address 5 -> read_data=0xDEADBEEF on the next cycle.
REQ-042 load_length=0 -> load_done pulses on the cycle after load_start, load_busy never rises, and memory is unchanged.
REQ-043 Reset asserted after the 2nd word of a 5-word burst -> FSM in IDLE, no load_done, and the first 2 words are still readable.
